// File: rtl/vend_pkg.sv
// Shared definitions for the beverage vending front-end: FSM states,
// coin denominations, default prices and timing constants.
package vend_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CREDIT = 3'd1,
        ISSUE  = 3'd2,
        WAIT   = 3'd3,
        PAYOUT = 3'd4
    } vend_state_e;

    localparam logic [9:0] COIN_NICKEL  = 10'd5;
    localparam logic [9:0] COIN_DIME    = 10'd10;
    localparam logic [9:0] COIN_QUARTER = 10'd25;
    localparam logic [9:0] COIN_DOLLAR  = 10'd100;

    // Prices must agree with the dispenser's own price table.
    localparam logic [9:0] VALUE_BEV1 = 10'd175;
    localparam logic [9:0] VALUE_BEV2 = 10'd75;
    localparam logic [9:0] VALUE_BEV3 = 10'd200;

    localparam logic [9:0]  DEF_MAX_CREDIT = 10'd1000;
    localparam logic [15:0] DEF_IDLE_TO    = 16'd5000;
    localparam logic [3:0]  DEF_DISP_TO    = 4'd8;

    // True for the four denominations the coin mechanism may deliver.
    function automatic logic coin_is_legal(input logic [9:0] value);
        logic legal;
        case (value)
            COIN_NICKEL, COIN_DIME, COIN_QUARTER, COIN_DOLLAR: legal = 1'b1;
            default:                                         legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/vend_coin_acc.sv
// Coin acceptor: legality check, capped credit adder and accept/reject pulses.
// The credit register itself lives in the top; this block tells it when and
// what to load.
module vend_coin_acc
    import vend_pkg::*;
#(
    parameter logic [9:0] MAX_CREDIT = DEF_MAX_CREDIT
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_valid,
    input  logic [9:0] coin_value,
    input  logic [9:0] credit,
    input  logic       allow,
    output logic       coin_add,
    output logic [9:0] credit_sum,
    output logic       coin_accept,
    output logic       coin_reject
);

    logic [10:0] sum_s;
    logic        fits_s;
    logic        add_s;
    logic        accept_r;
    logic        reject_r;

    // Eleven-bit sum so an over-cap coin cannot wrap into a small credit.
    always_comb begin
        sum_s  = {1'b0, credit} + {1'b0, coin_value};
        fits_s = (sum_s <= {1'b0, MAX_CREDIT});
        add_s  = coin_valid && allow && coin_is_legal(coin_value) && fits_s;
    end

    // One-cycle accept/reject pulses, aligned with the credit update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accept_r <= 1'b0;
            reject_r <= 1'b0;
        end else begin
            accept_r <= add_s;
            reject_r <= coin_valid && !add_s;
        end
    end

    assign coin_add    = add_s;
    assign credit_sum  = sum_s[9:0];
    assign coin_accept = accept_r;
    assign coin_reject = reject_r;

endmodule

// File: rtl/vend_sequencer.sv
// Vending front-end controller: accumulates credit, issues one request to the
// dispenser, waits for its response and pays out change or a refund.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter logic [9:0]  PRICE1     = VALUE_BEV1,
    parameter logic [9:0]  PRICE2     = VALUE_BEV2,
    parameter logic [9:0]  PRICE3     = VALUE_BEV3,
    parameter logic [9:0]  MAX_CREDIT = DEF_MAX_CREDIT,
    parameter logic [15:0] IDLE_TO    = DEF_IDLE_TO,
    parameter logic [3:0]  DISP_TO    = DEF_DISP_TO
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_valid,
    input  logic [9:0] coin_value,
    output logic       coin_accept,
    output logic       coin_reject,
    input  logic [2:0] sel,
    input  logic       cancel,
    output logic [9:0] credit,
    output logic       busy,
    output logic       low_credit,
    output logic [9:0] disp_money,
    output logic [2:0] disp_bev,
    input  logic [2:0] disp_out,
    input  logic [9:0] disp_change,
    output logic       refund_valid,
    output logic [9:0] refund_amt,
    output logic       vend_done,
    output logic       fault
);

    vend_state_e state_r, state_nxt_s;

    logic [9:0]  credit_r;
    logic [2:0]  bev_r;
    logic [3:0]  wait_cnt_r;
    logic [15:0] idle_cnt_r;

    logic [2:0]  sel_onehot_s;
    logic [9:0]  sel_price_s;
    logic        sel_ok_s;
    logic        low_s;
    logic        idle_exp_s;
    logic        allow_s;
    logic        disp_ok_s;
    logic        disp_bad_s;
    logic        wait_exp_s;
    logic        coin_add_s;
    logic [9:0]  credit_sum_s;

    logic        enter_issue_s;
    logic        enter_pay_s;
    logic        vend_ok_s;
    logic        busy_s;
    logic        fault_s;
    logic [9:0]  disp_money_s;
    logic [2:0]  disp_bev_s;
    logic [9:0]  refund_amt_s;

    logic        busy_r;
    logic        low_credit_r;
    logic [9:0]  disp_money_r;
    logic [2:0]  disp_bev_r;
    logic        refund_valid_r;
    logic [9:0]  refund_amt_r;
    logic        vend_done_r;
    logic        fault_r;

    // Selection encoder: lowest-numbered beverage wins when several are requested.
    always_comb begin
        if (sel[0]) begin
            sel_onehot_s = 3'b001;
            sel_price_s  = PRICE1;
        end else if (sel[1]) begin
            sel_onehot_s = 3'b010;
            sel_price_s  = PRICE2;
        end else if (sel[2]) begin
            sel_onehot_s = 3'b100;
            sel_price_s  = PRICE3;
        end else begin
            sel_onehot_s = 3'b000;
            sel_price_s  = 10'd0;
        end
    end

    // Event decode; cancel beats selection beats coin, and a consumed cycle rejects coins.
    always_comb begin
        idle_exp_s = (idle_cnt_r == (IDLE_TO - 16'd1));
        sel_ok_s   = (sel_onehot_s != 3'b000) && (credit_r >= sel_price_s);
        low_s      = (state_r == CREDIT) && !cancel && (sel_onehot_s != 3'b000)
                     && !sel_ok_s && !idle_exp_s;
        disp_ok_s  = (disp_out == bev_r);
        disp_bad_s = (disp_out != 3'b000) && !disp_ok_s;
        wait_exp_s = (wait_cnt_r == (DISP_TO - 4'd1));
        if (fault_r) begin
            allow_s = 1'b0;
        end else if (state_r == IDLE) begin
            allow_s = 1'b1;
        end else if (state_r == CREDIT) begin
            allow_s = !(cancel || sel_ok_s || idle_exp_s);
        end else begin
            allow_s = 1'b0;
        end
    end

    vend_coin_acc #(
        .MAX_CREDIT (MAX_CREDIT)
    ) u_coin_acc (
        .clk         (clk),
        .rst_n       (rst_n),
        .coin_valid  (coin_valid),
        .coin_value  (coin_value),
        .credit      (credit_r),
        .allow       (allow_s),
        .coin_add    (coin_add_s),
        .credit_sum  (credit_sum_s),
        .coin_accept (coin_accept),
        .coin_reject (coin_reject)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (coin_add_s) state_nxt_s = CREDIT;
                else            state_nxt_s = IDLE;
            end
            CREDIT: begin
                if (cancel)          state_nxt_s = PAYOUT;
                else if (sel_ok_s)   state_nxt_s = ISSUE;
                else if (idle_exp_s) state_nxt_s = PAYOUT;
                else                 state_nxt_s = CREDIT;
            end
            ISSUE: begin
                state_nxt_s = WAIT;
            end
            WAIT: begin
                if (disp_ok_s || disp_bad_s || wait_exp_s) state_nxt_s = PAYOUT;
                else                                       state_nxt_s = WAIT;
            end
            PAYOUT: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output logic: next values of the registered outputs, set on entry to a state.
    always_comb begin
        enter_issue_s = (state_r == CREDIT) && (state_nxt_s == ISSUE);
        enter_pay_s   = (state_r != PAYOUT) && (state_nxt_s == PAYOUT);
        vend_ok_s     = (state_r == WAIT) && disp_ok_s;
        busy_s        = (state_nxt_s == ISSUE) || (state_nxt_s == WAIT)
                        || (state_nxt_s == PAYOUT);
        fault_s       = fault_r || ((state_r == WAIT) && enter_pay_s && !vend_ok_s);
        if (enter_issue_s) begin
            disp_money_s = credit_r;
            disp_bev_s   = sel_onehot_s;
        end else begin
            disp_money_s = 10'd0;
            disp_bev_s   = 3'b000;
        end
        if (enter_pay_s && vend_ok_s) begin
            refund_amt_s = disp_change;
        end else if (enter_pay_s) begin
            refund_amt_s = credit_r;
        end else begin
            refund_amt_s = 10'd0;
        end
    end

    // Credit, latched selection and the two watchdog counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_r   <= 10'd0;
            bev_r      <= 3'b000;
            wait_cnt_r <= 4'd0;
            idle_cnt_r <= 16'd0;
        end else begin
            if (enter_pay_s) begin
                credit_r <= 10'd0;
            end else if (coin_add_s) begin
                credit_r <= credit_sum_s;
            end else begin
                credit_r <= credit_r;
            end
            if (enter_issue_s) begin
                bev_r <= sel_onehot_s;
            end else begin
                bev_r <= bev_r;
            end
            if ((state_r == WAIT) && (state_nxt_s == WAIT)) begin
                wait_cnt_r <= wait_cnt_r + 4'd1;
            end else begin
                wait_cnt_r <= 4'd0;
            end
            if ((state_r == CREDIT) && (state_nxt_s == CREDIT) && !coin_add_s && !low_s) begin
                idle_cnt_r <= idle_cnt_r + 16'd1;
            end else begin
                idle_cnt_r <= 16'd0;
            end
        end
    end

    // Registered outputs; fault stays set until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r         <= 1'b0;
            low_credit_r   <= 1'b0;
            disp_money_r   <= 10'd0;
            disp_bev_r     <= 3'b000;
            refund_valid_r <= 1'b0;
            refund_amt_r   <= 10'd0;
            vend_done_r    <= 1'b0;
            fault_r        <= 1'b0;
        end else begin
            busy_r         <= busy_s;
            low_credit_r   <= low_s;
            disp_money_r   <= disp_money_s;
            disp_bev_r     <= disp_bev_s;
            refund_valid_r <= enter_pay_s;
            refund_amt_r   <= refund_amt_s;
            vend_done_r    <= enter_pay_s && vend_ok_s;
            fault_r        <= fault_s;
        end
    end

    assign credit       = credit_r;
    assign busy         = busy_r;
    assign low_credit   = low_credit_r;
    assign disp_money   = disp_money_r;
    assign disp_bev     = disp_bev_r;
    assign refund_valid = refund_valid_r;
    assign refund_amt   = refund_amt_r;
    assign vend_done    = vend_done_r;
    assign fault        = fault_r;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer with a behavioural dispenser attached.
module tb_vend_sequencer;

    logic       clk;
    logic       rst_n;
    logic       coin_valid;
    logic [9:0] coin_value;
    logic       coin_accept;
    logic       coin_reject;
    logic [2:0] sel;
    logic       cancel;
    logic [9:0] credit;
    logic       busy;
    logic       low_credit;
    logic [9:0] disp_money;
    logic [2:0] disp_bev;
    logic [2:0] disp_out;
    logic [9:0] disp_change;
    logic       refund_valid;
    logic [9:0] refund_amt;
    logic       vend_done;
    logic       fault;

    int vectors;
    int miscompares;
    int n;

    // Dispenser model: answers one cycle after a request with the beverage and change.
    logic       disp_en;
    logic       dsp_rst;
    logic [2:0] dsp_out_r;
    logic [9:0] dsp_chg_r;
    logic [9:0] dsp_price;

    assign dsp_rst     = ~rst_n;
    assign disp_out    = disp_en ? dsp_out_r : 3'b000;
    assign disp_change = disp_en ? dsp_chg_r : 10'd0;

    always_comb begin
        case (disp_bev)
            3'b001:  dsp_price = 10'd175;
            3'b010:  dsp_price = 10'd75;
            3'b100:  dsp_price = 10'd200;
            default: dsp_price = 10'd0;
        endcase
    end

    always @(posedge clk or posedge dsp_rst) begin
        if (dsp_rst) begin
            dsp_out_r <= 3'b000;
            dsp_chg_r <= 10'd0;
        end else if (disp_bev != 3'b000 && disp_money >= dsp_price) begin
            dsp_out_r <= disp_bev;
            dsp_chg_r <= disp_money - dsp_price;
        end else begin
            dsp_out_r <= 3'b000;
            dsp_chg_r <= 10'd0;
        end
    end

    vend_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .coin_valid   (coin_valid),
        .coin_value   (coin_value),
        .coin_accept  (coin_accept),
        .coin_reject  (coin_reject),
        .sel          (sel),
        .cancel       (cancel),
        .credit       (credit),
        .busy         (busy),
        .low_credit   (low_credit),
        .disp_money   (disp_money),
        .disp_bev     (disp_bev),
        .disp_out     (disp_out),
        .disp_change  (disp_change),
        .refund_valid (refund_valid),
        .refund_amt   (refund_amt),
        .vend_done    (vend_done),
        .fault        (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [9:0] v);
        coin_valid = 1'b1;
        coin_value = v;
        tick();
        coin_valid = 1'b0;
        coin_value = 10'd0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        coin_valid  = 1'b0;
        coin_value  = 10'd0;
        sel         = 3'b000;
        cancel      = 1'b0;
        disp_en     = 1'b1;

        // Reset state
        #12;
        chk("rst_credit", {6'd0, credit}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_refund", {15'd0, refund_valid}, 16'd0);
        chk("rst_fault", {15'd0, fault}, 16'd0);
        #10 rst_n = 1'b1;

        // Vend 1: 100+100, bev1 at 175 -> change 25
        coin(10'd100);
        chk("v1_accept", {15'd0, coin_accept}, 16'd1);
        chk("v1_credit100", {6'd0, credit}, 16'd100);
        coin(10'd100);
        chk("v1_credit200", {6'd0, credit}, 16'd200);
        sel = 3'b001;
        tick();
        sel = 3'b000;
        chk("v1_bev", {13'd0, disp_bev}, 16'd1);
        chk("v1_money", {6'd0, disp_money}, 16'd200);
        chk("v1_busy", {15'd0, busy}, 16'd1);
        tick();
        chk("v1_bev_off", {13'd0, disp_bev}, 16'd0);
        chk("v1_money_off", {6'd0, disp_money}, 16'd0);
        coin_valid = 1'b1;
        coin_value = 10'd100;
        tick();
        coin_valid = 1'b0;
        chk("v1_busy_reject", {15'd0, coin_reject}, 16'd1);
        chk("v1_refund_valid", {15'd0, refund_valid}, 16'd1);
        chk("v1_refund_amt", {6'd0, refund_amt}, 16'd25);
        chk("v1_vend_done", {15'd0, vend_done}, 16'd1);
        chk("v1_credit_clr", {6'd0, credit}, 16'd0);
        tick();
        chk("v1_idle_busy", {15'd0, busy}, 16'd0);
        chk("v1_refund_off", {15'd0, refund_valid}, 16'd0);

        // Low credit then exact payment for bev2 (75)
        coin(10'd25);
        coin(10'd25);
        chk("v2_credit50", {6'd0, credit}, 16'd50);
        sel = 3'b010;
        tick();
        sel = 3'b000;
        chk("v2_low_credit", {15'd0, low_credit}, 16'd1);
        chk("v2_no_issue", {13'd0, disp_bev}, 16'd0);
        chk("v2_not_busy", {15'd0, busy}, 16'd0);
        tick();
        chk("v2_low_pulse", {15'd0, low_credit}, 16'd0);
        coin(10'd25);
        chk("v2_credit75", {6'd0, credit}, 16'd75);
        sel = 3'b010;
        tick();
        sel = 3'b000;
        chk("v2_bev", {13'd0, disp_bev}, 16'd2);
        chk("v2_money", {6'd0, disp_money}, 16'd75);
        tick();
        tick();
        chk("v2_refund_valid", {15'd0, refund_valid}, 16'd1);
        chk("v2_refund_amt", {6'd0, refund_amt}, 16'd0);
        chk("v2_vend_done", {15'd0, vend_done}, 16'd1);
        tick();

        // Credit ceiling and illegal coin
        for (int i = 0; i < 10; i++) coin(10'd100);
        chk("v3_credit1000", {6'd0, credit}, 16'd1000);
        coin(10'd5);
        chk("v3_cap_reject", {15'd0, coin_reject}, 16'd1);
        chk("v3_cap_noaccept", {15'd0, coin_accept}, 16'd0);
        chk("v3_cap_credit", {6'd0, credit}, 16'd1000);
        coin(10'd7);
        chk("v3_illegal_reject", {15'd0, coin_reject}, 16'd1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("v3_cancel_amt", {6'd0, refund_amt}, 16'd1000);
        chk("v3_cancel_done", {15'd0, vend_done}, 16'd0);
        tick();

        // Cancel, selection and coin in one cycle: cancel wins, coin rejected
        coin(10'd100);
        coin(10'd25);
        chk("v4_credit125", {6'd0, credit}, 16'd125);
        cancel     = 1'b1;
        sel        = 3'b010;
        coin_valid = 1'b1;
        coin_value = 10'd5;
        tick();
        cancel     = 1'b0;
        sel        = 3'b000;
        coin_valid = 1'b0;
        chk("v4_refund_valid", {15'd0, refund_valid}, 16'd1);
        chk("v4_refund_amt", {6'd0, refund_amt}, 16'd125);
        chk("v4_vend_done", {15'd0, vend_done}, 16'd0);
        chk("v4_no_issue", {13'd0, disp_bev}, 16'd0);
        chk("v4_coin_reject", {15'd0, coin_reject}, 16'd1);
        tick();

        // Inactivity refund after 5000 idle cycles
        coin(10'd10);
        n = 0;
        while (!refund_valid && n < 6000) begin
            tick();
            n++;
        end
        chk("v5_idle_cycles", n[15:0], 16'd5000);
        chk("v5_idle_amt", {6'd0, refund_amt}, 16'd10);
        chk("v5_idle_done", {15'd0, vend_done}, 16'd0);
        tick();

        // Asynchronous reset while waiting on the dispenser
        coin(10'd100);
        sel = 3'b010;
        tick();
        sel = 3'b000;
        tick();
        chk("v6_wait_busy", {15'd0, busy}, 16'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("v6_rst_credit", {6'd0, credit}, 16'd0);
        chk("v6_rst_busy", {15'd0, busy}, 16'd0);
        chk("v6_rst_refund", {15'd0, refund_valid}, 16'd0);
        #2 rst_n = 1'b1;
        tick();
        tick();
        chk("v6_idle_credit", {6'd0, credit}, 16'd0);
        chk("v6_idle_refund", {15'd0, refund_valid}, 16'd0);

        // Dispenser no-response fault
        disp_en = 1'b0;
        coin(10'd100);
        sel = 3'b010;
        tick();
        sel = 3'b000;
        n = 0;
        while (!refund_valid && n < 50) begin
            tick();
            n++;
        end
        chk("v7_timeout_cycles", n[15:0], 16'd9);
        chk("v7_fault", {15'd0, fault}, 16'd1);
        chk("v7_refund_amt", {6'd0, refund_amt}, 16'd100);
        chk("v7_vend_done", {15'd0, vend_done}, 16'd0);
        tick();
        disp_en = 1'b1;
        coin(10'd25);
        chk("v7_fault_reject", {15'd0, coin_reject}, 16'd1);
        chk("v7_fault_credit", {6'd0, credit}, 16'd0);
        chk("v7_fault_sticky", {15'd0, fault}, 16'd1);

        // Reset clears the fault and coins are accepted again
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        tick();
        chk("v8_fault_clr", {15'd0, fault}, 16'd0);
        coin(10'd25);
        chk("v8_accept", {15'd0, coin_accept}, 16'd1);
        chk("v8_credit", {6'd0, credit}, 16'd25);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
